// File: rtl/paddsb_seq_pkg.sv
// Shared definitions for the sequential nibble adder.
// Op codes, FSM states and saturation constants.
package paddsb_seq_defs;

  localparam int NIB_W = 4;
  localparam int NNIB_N = 4;
  localparam int DW_W = NIB_W * NNIB_N;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_PADDSB = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8000;
  localparam logic [3:0] NIB_SAT = 4'hF;

endpackage

// File: rtl/cla_4bit.sv
// 4-bit carry-lookahead adder slice.
// sub inverts b and forces a carry-in.
module cla_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       sub,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] bb;
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // generate/propagate and lookahead carries
  always_comb begin
    bb = b ^ {4{sub}};
    g = a & bb;
    p = a ^ bb;
    c[0] = cin | sub;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0])
         | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    sum = p ^ c[3:0];
    cout = c[4];
  end

endmodule

// File: rtl/paddsb_seq.sv
// Multi-cycle saturating adder sharing one cla_4bit
// across four nibbles, least significant first.
module paddsb_seq
  import paddsb_seq_defs::*;
#(
  parameter int NIB = 4,
  parameter int NNIB = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [NIB*NNIB-1:0] a,
  input  logic [NIB*NNIB-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [NIB*NNIB-1:0] result,
  output logic                ovfl
);

  localparam int DW = NIB * NNIB;

  state_e state;
  state_e state_d;

  logic [DW-1:0] a_lat;
  logic [DW-1:0] b_lat;
  logic [1:0] op_lat;
  logic [1:0] idx;
  logic carry;
  logic sat;
  logic [DW-NIB-1:0] nq;

  logic accept;
  logic last;
  logic is_pad;
  logic [NIB-1:0] nib_a;
  logic [NIB-1:0] nib_b;
  logic cin;
  logic [NIB-1:0] s;
  logic co;
  logic [NIB-1:0] nib_st;
  logic [DW-1:0] raw;
  logic sovf;
  logic [DW-1:0] fin_res;
  logic fin_ovfl;

  assign accept = start && (state != S_RUN);
  assign last = (idx == 2'(NNIB - 1));
  assign is_pad = (op_lat == OP_PADDSB);

  // nibble select, live slice sum and final result
  always_comb begin
    nib_a = a_lat[idx*NIB +: NIB];
    nib_b = b_lat[idx*NIB +: NIB];
    cin = is_pad ? 1'b0 : carry;
    nib_st = (is_pad && co) ? NIB_SAT : s;
    raw = {s, nq};
    sovf = (a_lat[DW-1] == b_lat[DW-1])
        && (raw[DW-1] != a_lat[DW-1]);
    fin_res = raw;
    fin_ovfl = 1'b0;
    if (is_pad) begin
      fin_res = {nib_st, nq};
      fin_ovfl = sat | co;
    end else if (sovf) begin
      fin_res = a_lat[DW-1] ? SAT_NEG : SAT_POS;
      fin_ovfl = 1'b1;
    end
  end

  cla_4bit u_cla (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (cin),
    .sub  (1'b0),
    .sum  (s),
    .cout (co)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else state <= state_d;
  end

  // next state and handshake outputs
  always_comb begin
    state_d = state;
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (last) state_d = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        state_d = start ? S_RUN : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // operand latch, nibble sequencing and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_lat <= '0;
      b_lat <= '0;
      op_lat <= OP_ADD;
      idx <= 2'd0;
      carry <= 1'b0;
      sat <= 1'b0;
      nq <= '0;
      result <= '0;
      ovfl <= 1'b0;
    end else if (accept) begin
      a_lat <= a;
      b_lat <= (op == OP_SUB) ? ~b : b;
      op_lat <= op;
      idx <= 2'd0;
      carry <= (op == OP_SUB);
      sat <= 1'b0;
    end else if (state == S_RUN) begin
      carry <= co;
      idx <= idx + 2'd1;
      if (last) begin
        result <= fin_res;
        ovfl <= fin_ovfl;
      end else begin
        nq[idx*NIB +: NIB] <= nib_st;
        sat <= sat | (is_pad & co);
      end
    end
  end

endmodule
